// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, next-PC select encodings and fetch FSM states.
package cpu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IMM_W = 24;

    localparam logic [1:0] PC_S_SEQ = 2'b00;
    localparam logic [1:0] PC_S_BR  = 2'b01;
    localparam logic [1:0] PC_S_ALU = 2'b10;
    localparam logic [1:0] PC_S_RSV = 2'b11;

    typedef enum logic [1:0] {
        FS_IDLE = 2'b00,
        FS_REQ  = 2'b01,
        FS_DONE = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: sequential, PC-relative branch or ALU target, plus the error condition.
module pc_next_sel
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0]  pc,
    input  logic [1:0]       pc_s,
    input  logic [IMM_W-1:0] imm24,
    input  logic [XLEN-1:0]  alu_f,
    output logic [XLEN-1:0]  pc_next,
    output logic             err
);

    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] br_off;

    assign pc_seq = XLEN'(pc + XLEN'(4));
    // Word offset: sign-extend the 24-bit field and scale by 4.
    assign br_off = {{(XLEN-IMM_W-2){imm24[IMM_W-1]}}, imm24, 2'b00};

    always_comb begin
        pc_next = pc;
        err     = 1'b0;
        case (pc_s)
            PC_S_SEQ: pc_next = pc_seq;
            PC_S_BR:  pc_next = XLEN'(pc_seq + br_off);
            PC_S_ALU: begin
                pc_next = {alu_f[XLEN-1:2], 2'b00};
                err     = |alu_f[1:0];
            end
            default:  err = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, fetches over a req/ready handshake.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_ir,
    input  logic             write_pc,
    input  logic [1:0]       pc_s,
    input  logic [IMM_W-1:0] imm24,
    input  logic [XLEN-1:0]  alu_f,
    input  logic [XLEN-1:0]  imem_rdata,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    output logic [XLEN-1:0]  I,
    output logic             W_IR_valid,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  fetch_cnt,
    output logic             fetch_err
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc_next;
    logic            sel_err;

    pc_next_sel u_pc_next_sel (
        .pc      (pc),
        .pc_s    (pc_s),
        .imm24   (imm24),
        .alu_f   (alu_f),
        .pc_next (pc_next),
        .err     (sel_err)
    );

    // Request and address decode straight from registered state.
    assign imem_req  = (state == FS_REQ);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FS_IDLE;
            pc         <= RESET_PC;
            I          <= '0;
            W_IR_valid <= 1'b0;
            fetch_cnt  <= '0;
            fetch_err  <= 1'b0;
        end else begin
            case (state)
                FS_IDLE, FS_DONE: begin
                    if (write_pc) begin
                        pc <= pc_next;
                        if (sel_err) fetch_err <= 1'b1;
                    end
                    if (write_ir) begin
                        state      <= FS_REQ;
                        W_IR_valid <= 1'b0;
                    end
                end
                FS_REQ: begin
                    // Controller strobes are illegal while a fetch is in flight.
                    if (write_ir || write_pc) fetch_err <= 1'b1;
                    if (imem_ready) begin
                        I          <= imem_rdata;
                        pc         <= XLEN'(pc + XLEN'(4));
                        W_IR_valid <= 1'b1;
                        fetch_cnt  <= XLEN'(fetch_cnt + XLEN'(1));
                        state      <= FS_DONE;
                    end
                end
                default: state <= FS_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the multi-cycle controller. It owns the program counter and instruction register, reads instructions from a variable-latency instruction memory using a req/ready handshake, and presents the fetched word on `I` with a `W_IR_valid` qualifier. The controller drives it through `write_ir`, `write_pc` and `pc_s`.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset; must be word-aligned.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `write_ir`  in  1  one-cycle fetch request from the controller.
- `write_pc`  in  1  one-cycle PC update from the controller.
- `pc_s`  in  2  next-PC select: 00 sequential, 01 branch, 10 ALU, 11 reserved.
- `imm24`  in  24  branch offset field from the decoded instruction.
- `alu_f`  in  32  ALU result; the PC source when `pc_s`=10.
- `imem_rdata`  in  32  instruction memory read data; valid while `imem_ready`=1.
- `imem_ready`  in  1  memory accepts the request and returns data in the same cycle.
- `imem_req`  out  1  read request; held until `imem_ready`.
- `imem_addr`  out  32  byte address; equals `pc` while `imem_req`=1.
- `I`  out  32  instruction register.
- `W_IR_valid`  out  1  `I` holds the result of the most recent fetch.
- `pc`  out  32  current PC.
- `fetch_cnt`  out  32  count of completed fetches; wraps modulo 2^32.
- `fetch_err`  out  1  sticky protocol-error flag.

## Operation
- States: IDLE, REQ, DONE.
  - IDLE --write_ir--> REQ.
  - REQ --imem_ready--> DONE.
  - DONE --write_ir--> REQ.
  - No other transitions.
- `imem_req` = (state==REQ). This is a registered-state decode with no input-to-output combinational path.
- Accepting `write_ir` in IDLE or DONE clears `W_IR_valid` on the same edge that enters REQ.
- Handshake completes on any cycle in REQ with `imem_ready`=1. On that edge:
  - `I` <= `imem_rdata`
  - `pc` <= `pc`+4
  - `W_IR_valid` <= 1
  - `fetch_cnt` <= `fetch_cnt`+1
- `write_pc` in IDLE or DONE updates `pc` according to `pc_s`:
  - 00: `pc`+4.
  - 01: `pc` + 4 + (sign_extend(`imm24`) << 2). Because `pc` has already advanced past the fetched instruction, this yields fetched_address + 8 + offset.
  - 10: {`alu_f`[31:2], 2'b00}. Low bits are forced to zero; if `alu_f`[1:0] ≠ 0, `fetch_err` is set.
  - 11: `pc` is unchanged and `fetch_err` is set.
- Arithmetic is 32-bit modulo 2^32. `pc` wraps from 32'hFFFF_FFFC to 0 without error.
- Simultaneous `write_ir` and `write_pc` in IDLE/DONE: `pc` updates on that edge, so the fetch in REQ uses the new `pc`.
- `write_ir` or `write_pc` while in REQ: the strobe is ignored and `fetch_err` is set. The in-flight request is unaffected.
- `I` and `W_IR_valid` hold their values in DONE indefinitely until the next accepted `write_ir`.
- `fetch_err` clears only on `rst`.

## Timing
- Reset values:
  - state IDLE
  - `pc`=`RESET_PC`
  - `I`=0
  - `W_IR_valid`=0
  - `imem_req`=0
  - `fetch_cnt`=0
  - `fetch_err`=0
- Minimum fetch latency: `write_ir` at cycle t; `imem_req`=1 at t+1; with `imem_ready` at t+1, `I` and `W_IR_valid`=1 at t+2.
- Each wait cycle of `imem_ready`=0 in REQ adds one cycle. `imem_addr` stays stable throughout REQ.
- `rst` asserted during REQ abandons the request: `imem_req`=0 from the next cycle, and no `I` or `pc` update occurs even if `imem_ready` is high in the reset cycle.
- `write_pc` takes effect one edge after assertion. The new `pc` is visible the following cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - `pc_s` encodings: `PC_S_SEQ`=2'b00, `PC_S_BR`=2'b01, `PC_S_ALU`=2'b10.
  - Fetch state encoding: `FS_IDLE`, `FS_REQ`, `FS_DONE`.
- One combinational sub-module `pc_next_sel` takes `pc`, `pc_s`, `imm24`, `alu_f` and produces the next PC and the error condition. The FSM, registers and counter stay in `fetch_unit`.

## Test plan
- Reset, then `write_ir` with `imem_ready` tied high and `imem_rdata`=32'hE3A01005 → `imem_addr`=0 at t+1; at t+2 `I`=32'hE3A01005, `W_IR_valid`=1, `pc`=4, `fetch_cnt`=1.
- `imem_ready` held low for 3 cycles in REQ → `imem_req` and `imem_addr` stable for 4 cycles; `W_IR_valid` rises exactly one cycle after the `imem_ready` cycle.
- After a fetch from address 8 (`pc`=12), `write_pc` with `pc_s`=01 and `imm24`=24'hFFFFFE → `pc`=8. With `imm24`=24'h000001 → `pc`=20.
- `write_pc` with `pc_s`=10, `alu_f`=32'h0000_1003 → `pc`=32'h1000, `fetch_err`=1. Next, `pc_s`=11 → `pc` unchanged.
- `write_ir` and `write_pc` (`pc_s`=10, `alu_f`=32'h40) in the same DONE cycle → next REQ has `imem_addr`=32'h40. A `write_pc` during REQ is ignored and sets `fetch_err`.
- `rst` pulsed during REQ with `imem_ready`=1 → `I` unchanged, `pc`=`RESET_PC`, `W_IR_valid`=0, `imem_req`=0 the next cycle, `fetch_cnt`=0.
